mac_seq_acc: RTL and testbench



---
 rtl/mac_pkg.sv | 37 +++
 rtl/mac_row_sum.sv | 31 +++
 rtl/mac_seq_acc.sv | 164 ++++++++++++++++
 tb/tb_mac_seq_acc.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared types and helpers for the sequential binary-ifmap MAC.
// Default kernel/weight/accumulator sizes and the saturating clip used when MAC_SEQ_ACC_SAT_EN is defined.
package mac_pkg;

    localparam int K_DEF            = 5;
    localparam int FILTER_WIDTH_DEF = 8;
    localparam int OUTPUT_WIDTH_DEF = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROW  = 2'd1,
        OUT  = 2'd2
    } mac_state_t;

    // Sign-extends the low w bits of v to 64 bits (w in 1..64).
    function automatic logic signed [63:0] sext64(input logic [63:0] v, input int unsigned w);
        logic signed [63:0] t;
        t = signed'(v << (64 - w));
        return t >>> (64 - w);
    endfunction

    // Clamps v to the signed range of an ow-bit two's-complement number (ow in 2..63).
    function automatic logic signed [63:0] sat_clip(input logic signed [63:0] v, input int unsigned ow);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/mac_row_sum.sv
// Combinational gated sum of one kernel row: weight c contributes only when spike bit c is set.
// The sum is formed at OUTPUT_WIDTH and wraps modulo 2^OUTPUT_WIDTH.
module mac_row_sum
    import mac_pkg::*;
#(
    parameter int K            = K_DEF,
    parameter int FILTER_WIDTH = FILTER_WIDTH_DEF,
    parameter int OUTPUT_WIDTH = OUTPUT_WIDTH_DEF
) (
    input  logic        [K*FILTER_WIDTH-1:0] i_weights,
    input  logic        [K-1:0]              i_spikes,
    output logic signed [OUTPUT_WIDTH-1:0]   o_sum
);

    logic signed [FILTER_WIDTH-1:0] w_weight;
    logic signed [OUTPUT_WIDTH-1:0] w_sum;

    always_comb begin
        w_weight = '0;
        w_sum    = '0;
        for (int c = 0; c < K; c++) begin
            w_weight = i_weights[c*FILTER_WIDTH +: FILTER_WIDTH];
            if (i_spikes[c]) begin
                w_sum = w_sum + OUTPUT_WIDTH'(w_weight);
            end
        end
    end

    assign o_sum = w_sum;

endmodule

// File: rtl/mac_seq_acc.sv
// Sequential KxK binary-ifmap MAC: one kernel row per cycle, psum accumulated over C_IN channels.
// Optional MAC_SEQ_ACC_SAT_EN: saturating row accumulation plus a sticky sat_flag output.
module mac_seq_acc
    import mac_pkg::*;
#(
    parameter int K            = K_DEF,
    parameter int FILTER_WIDTH = FILTER_WIDTH_DEF,
    parameter int OUTPUT_WIDTH = OUTPUT_WIDTH_DEF,
    parameter int C_IN         = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           filt_valid,
    output logic                           filt_ready,
    input  logic [K*K*FILTER_WIDTH-1:0]    filt_data,
    input  logic                           ifmap_valid,
    output logic                           ifmap_ready,
    input  logic [K*K-1:0]                 ifmap_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic signed [OUTPUT_WIDTH-1:0] out_data
`ifdef MAC_SEQ_ACC_SAT_EN
    ,
    output logic                           sat_flag
`endif
);

    localparam int RW = (K > 1) ? $clog2(K) : 1;
    localparam int CW = (C_IN > 1) ? $clog2(C_IN) : 1;

    mac_state_t r_state;
    mac_state_t w_next;

    logic [RW-1:0]                          r_row;
    logic [CW-1:0]                          r_ch;
    logic signed [OUTPUT_WIDTH-1:0]         r_acc;
    logic [K-1:0][K*FILTER_WIDTH-1:0]       r_filt;
    logic [K-1:0][K-1:0]                    r_ifmap;
    logic                                   r_sat;

    logic                                   w_take;
    logic                                   w_last_row;
    logic                                   w_last_ch;
    logic                                   w_clip;
    logic signed [OUTPUT_WIDTH-1:0]         w_row_sum;
    logic signed [OUTPUT_WIDTH-1:0]         w_acc_sum;

    // Join semantics: both operands must be valid together, never while reset is held.
    assign w_take     = rst_n && (r_state == IDLE) && filt_valid && ifmap_valid;
    assign w_last_row = (r_row == RW'(K - 1));
    assign w_last_ch  = (r_ch == CW'(C_IN - 1));

    mac_row_sum #(
        .K            (K),
        .FILTER_WIDTH (FILTER_WIDTH),
        .OUTPUT_WIDTH (OUTPUT_WIDTH)
    ) u_row_sum (
        .i_weights (r_filt[r_row]),
        .i_spikes  (r_ifmap[r_row]),
        .o_sum     (w_row_sum)
    );

`ifdef MAC_SEQ_ACC_SAT_EN
    logic signed [63:0] w_wide_sum;
    logic signed [63:0] w_wide_clip;

    always_comb begin
        w_wide_sum  = sext64(64'(r_acc), OUTPUT_WIDTH) + sext64(64'(w_row_sum), OUTPUT_WIDTH);
        w_wide_clip = sat_clip(w_wide_sum, OUTPUT_WIDTH);
        w_clip      = (w_wide_clip != w_wide_sum);
        w_acc_sum   = OUTPUT_WIDTH'(w_wide_clip);
    end

    assign sat_flag = r_sat;
`else
    assign w_clip    = 1'b0;
    assign w_acc_sum = r_acc + w_row_sum;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        filt_ready  = w_take;
        ifmap_ready = w_take;
        out_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_take) begin
                    w_next = ROW;
                end
            end
            ROW: begin
                if (w_last_row) begin
                    w_next = w_last_ch ? OUT : IDLE;
                end
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Control and accumulator: cleared by reset so an aborted window leaves no residue.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_row <= '0;
            r_ch  <= '0;
            r_sat <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_take) begin
                        r_row <= '0;
                    end
                end
                ROW: begin
                    r_acc <= w_acc_sum;
                    if (w_clip) begin
                        r_sat <= 1'b1;
                    end
                    if (w_last_row) begin
                        r_row <= '0;
                        if (!w_last_ch) begin
                            r_ch <= r_ch + 1'b1;
                        end
                    end else begin
                        r_row <= r_row + 1'b1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        r_acc <= '0;
                        r_ch  <= '0;
                        r_sat <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Operand capture: only loaded on the accept cycle, so inputs are ignored in ROW/OUT.
    always_ff @(posedge clk) begin
        if (w_take) begin
            r_filt  <= filt_data;
            r_ifmap <= ifmap_data;
        end
    end

    assign out_data = r_acc;

endmodule

// File: tb/tb_mac_seq_acc.sv
// Scoreboard bench for mac_seq_acc: two instances (C_IN=1 and C_IN=3) driven by directed and random windows.
// Expected psums come from an integer reference model; a negedge monitor pops and compares on each output handshake.
module tb_mac_seq_acc;

    localparam int K    = 5;
    localparam int FW   = 8;
    localparam int OW   = 12;
    localparam int NI   = 2;
    localparam int MAXV = (1 << (OW - 1)) - 1;
    localparam int MINV = -(1 << (OW - 1));

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   fv    [NI];
    logic                   iv    [NI];
    logic                   fr    [NI];
    logic                   ir    [NI];
    logic                   ov    [NI];
    logic                   ordy  [NI];
    logic                   man_rdy [NI];
    logic                   rnd_bit [NI];
    logic                   rnd_rdy;
    logic [K*K*FW-1:0]      fd    [NI];
    logic [K*K-1:0]         idat  [NI];
    logic signed [OW-1:0]   od    [NI];
`ifdef MAC_SEQ_ACC_SAT_EN
    logic                   sf    [NI];
`endif

    int n_tests = 0;
    int n_fail  = 0;

    int expv_q [NI][$];
    bit exps_q [NI][$];
    int part_sum [NI];
    int part_cnt [NI];
    bit part_sat [NI];
    int last_val [NI];

    always #5 clk = ~clk;

    assign ordy[0] = rnd_rdy ? rnd_bit[0] : man_rdy[0];
    assign ordy[1] = rnd_rdy ? rnd_bit[1] : man_rdy[1];

    mac_seq_acc #(.K(K), .FILTER_WIDTH(FW), .OUTPUT_WIDTH(OW), .C_IN(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .filt_valid(fv[0]), .filt_ready(fr[0]), .filt_data(fd[0]),
        .ifmap_valid(iv[0]), .ifmap_ready(ir[0]), .ifmap_data(idat[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0])
`ifdef MAC_SEQ_ACC_SAT_EN
        , .sat_flag(sf[0])
`endif
    );

    mac_seq_acc #(.K(K), .FILTER_WIDTH(FW), .OUTPUT_WIDTH(OW), .C_IN(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .filt_valid(fv[1]), .filt_ready(fr[1]), .filt_data(fd[1]),
        .ifmap_valid(iv[1]), .ifmap_ready(ir[1]), .ifmap_data(idat[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1])
`ifdef MAC_SEQ_ACC_SAT_EN
        , .sat_flag(sf[1])
`endif
    );

    function automatic int cin_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic int wrap_ow(input int v);
        logic signed [OW-1:0] t;
        t = v[OW-1:0];
        return int'(t);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Reference: psum = sum of weights whose spike is set, over all channels, reduced to OW bits.
    function automatic void model_channel(input int i, input logic [K*K*FW-1:0] f, input logic [K*K-1:0] m);
        logic signed [FW-1:0] w;
        int rs;
        for (int r = 0; r < K; r++) begin
            rs = 0;
            for (int c = 0; c < K; c++) begin
                w = f[(r*K+c)*FW +: FW];
                if (m[r*K+c]) rs += int'(w);
            end
            part_sum[i] += rs;
`ifdef MAC_SEQ_ACC_SAT_EN
            if (part_sum[i] > MAXV) begin
                part_sum[i] = MAXV;
                part_sat[i] = 1'b1;
            end else if (part_sum[i] < MINV) begin
                part_sum[i] = MINV;
                part_sat[i] = 1'b1;
            end
`endif
        end
        part_cnt[i]++;
        if (part_cnt[i] == cin_of(i)) begin
            expv_q[i].push_back(wrap_ow(part_sum[i]));
            exps_q[i].push_back(part_sat[i]);
            part_sum[i] = 0;
            part_cnt[i] = 0;
            part_sat[i] = 1'b0;
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NI; i++) begin
            part_sum[i] = 0;
            part_cnt[i] = 0;
            part_sat[i] = 1'b0;
        end
    endfunction

    function automatic logic [K*K*FW-1:0] fill_w(input logic [FW-1:0] w);
        logic [K*K*FW-1:0] f;
        for (int s = 0; s < K*K; s++) f[s*FW +: FW] = w;
        return f;
    endfunction

    function automatic logic [K*K*FW-1:0] rand_w();
        logic [K*K*FW-1:0] f;
        for (int s = 0; s < K*K; s++) f[s*FW +: FW] = FW'($urandom_range(0, 255));
        return f;
    endfunction

    function automatic logic [K*K-1:0] rand_m();
        logic [K*K-1:0] m;
        m = (K*K)'($urandom);
        if ($urandom_range(0, 7) == 0) m = '0;
        return m;
    endfunction

    task automatic send(input int i, input logic [K*K*FW-1:0] f, input logic [K*K-1:0] m);
        int n;
        n = 0;
        fd[i] = f;
        idat[i] = m;
        fv[i] = 1'b1;
        iv[i] = 1'b1;
        #1;
        while (!(fr[i] && ir[i]) && n <= 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n > 300) begin
            fail_now($sformatf("send_timeout_dut%0d", i));
        end else begin
            @(posedge clk);
            model_channel(i, f, m);
            #1;
        end
        fv[i] = 1'b0;
        iv[i] = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((expv_q[0].size() != 0 || expv_q[1].size() != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) fail_now("drain_timeout");
        repeat (2) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < NI; i++) begin
                if (ov[i] && ordy[i]) begin
                    if (expv_q[i].size() == 0) begin
                        fail_now($sformatf("unexpected_out_dut%0d value=%0d", i, od[i]));
                    end else begin
                        check($sformatf("psum_dut%0d", i), int'(od[i]), expv_q[i].pop_front());
`ifdef MAC_SEQ_ACC_SAT_EN
                        check($sformatf("satflag_dut%0d", i), int'(sf[i]), int'(exps_q[i].pop_front()));
`else
                        void'(exps_q[i].pop_front());
`endif
                        last_val[i] = int'(od[i]);
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            for (int i = 0; i < NI; i++) rnd_bit[i] = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic signed [OW-1:0] held;
        logic [K*K*FW-1:0]    f;
        int n;
        rnd_rdy = 1'b0;
        for (int i = 0; i < NI; i++) begin
            rnd_bit[i] = 1'b1;
            man_rdy[i] = 1'b1;
            fv[i] = 1'b1;
            iv[i] = 1'b1;
            fd[i] = '0;
            idat[i] = '0;
            last_val[i] = 0;
        end
        model_reset();
        rst_n = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("rst_filt_ready_dut%0d", i), int'(fr[i]), 0);
            check($sformatf("rst_ifmap_ready_dut%0d", i), int'(ir[i]), 0);
            check($sformatf("rst_out_valid_dut%0d", i), int'(ov[i]), 0);
            check($sformatf("rst_out_data_dut%0d", i), int'(od[i]), 0);
            fv[i] = 1'b0;
            iv[i] = 1'b0;
        end
        rst_n = 1'b1;
        @(negedge clk);

        // All ones: 25, first valid on the sixth cycle after capture
        send(0, fill_w(8'h01), '1);
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (ov[0]) break;
        end
        check("latency", n, K + 1);
        drain();
        check("ones_25", last_val[0], 25);

        send(0, fill_w(8'h7F), 25'h000001F);
        drain();
        check("row0_635", last_val[0], 635);

        send(0, fill_w(8'h7F), '1);
        drain();
`ifdef MAC_SEQ_ACC_SAT_EN
        check("all127_sat", last_val[0], 2047);
`else
        check("all127_wrap", last_val[0], -921);
`endif

        // Three channels of -1: one output only
        for (int ch = 0; ch < 3; ch++) begin
            send(1, fill_w(8'hFF), '1);
            if (ch < 2) begin
                repeat (K + 1) @(negedge clk);
                check($sformatf("no_out_after_ch%0d", ch), int'(ov[1]), 0);
            end
        end
        drain();
        check("cin3_m75", last_val[1], -75);

        // Back-pressure: output held, no new window accepted
        man_rdy[0] = 1'b0;
        send(0, rand_w(), rand_m());
        n = 0;
        while (!ov[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("stall_valid_seen", int'(ov[0]), 1);
        held = od[0];
        fv[0] = 1'b1;
        iv[0] = 1'b1;
        fd[0] = rand_w();
        idat[0] = '1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("stall_valid", int'(ov[0]), 1);
            check("stall_data", int'(od[0]), int'(held));
            check("stall_filt_ready", int'(fr[0]), 0);
        end
        fv[0] = 1'b0;
        iv[0] = 1'b0;
        man_rdy[0] = 1'b1;
        drain();

        // Lone filt_valid is never accepted; raising ifmap_valid captures at once
        f = rand_w();
        fd[0] = f;
        idat[0] = 25'h1555555;
        fv[0] = 1'b1;
        iv[0] = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("lone_filt_ready", int'(fr[0]), 0);
            check("lone_ifmap_ready", int'(ir[0]), 0);
        end
        iv[0] = 1'b1;
        #1;
        check("join_filt_ready", int'(fr[0]), 1);
        check("join_ifmap_ready", int'(ir[0]), 1);
        @(posedge clk);
        model_channel(0, f, 25'h1555555);
        #1;
        fv[0] = 1'b0;
        iv[0] = 1'b0;
        drain();

        // Reset during channel 1 discards the partial sum
        send(1, fill_w(8'h40), '1);
        repeat (K + 1) @(negedge clk);
        send(1, fill_w(8'h40), '1);
        @(negedge clk);
        fv[1] = 1'b1;
        iv[1] = 1'b1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_out_valid", int'(ov[1]), 0);
        check("midrst_out_data", int'(od[1]), 0);
        check("midrst_filt_ready", int'(fr[1]), 0);
        check("midrst_ifmap_ready", int'(ir[1]), 0);
        model_reset();
        @(negedge clk);
        fv[1] = 1'b0;
        iv[1] = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        for (int ch = 0; ch < 3; ch++) send(1, fill_w(8'h02), '1);
        drain();
        check("after_rst_150", last_val[1], 150);

        // Random windows with random back-pressure on both instances
        rnd_rdy = 1'b1;
        fork
            begin
                for (int k = 0; k < 30; k++) send(0, rand_w(), rand_m());
            end
            begin
                for (int k = 0; k < 30; k++) send(1, rand_w(), rand_m());
            end
        join
        drain();
        rnd_rdy = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
